// File: rtl/skinny_sbox_feeder_pkg.sv
// rtl/skinny_sbox_feeder_pkg.sv - shared types and constants for the SKINNY S-box feeder
//
// Purpose : FSM state encoding, nibble count, PRNG tap positions, the default
//           PRNG seed and the 72-step LFSR advance used by skinny_prng72.
// Ports   : none (package skinny_feeder_pkg).
package skinny_feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } feeder_state_e;

   localparam int NIBBLES = 16;

   // Fibonacci LFSR x^72 + x^66 + x^25 + x^19 + 1, taps numbered from 1.
   localparam int LFSR_W    = 72;
   localparam int LFSR_TAP0 = 72;
   localparam int LFSR_TAP1 = 66;
   localparam int LFSR_TAP2 = 25;
   localparam int LFSR_TAP3 = 19;

   localparam logic [71:0] SEED_DEFAULT_VAL = 72'h5A_C3E1_0F96_B4D2_8771;

   // One FEED cycle consumes a full 72-bit word of fresh randomness, so the
   // register moves 72 single-bit steps at once.
   function automatic logic [71:0] lfsr_adv72(input logic [71:0] s);
      logic [71:0] v;
      v = s;
      for (int i = 0; i < LFSR_W; i++) begin
         v = {v[70:0], v[LFSR_TAP0-1] ^ v[LFSR_TAP1-1] ^ v[LFSR_TAP2-1] ^ v[LFSR_TAP3-1]};
      end
      return v;
   endfunction

endpackage

// File: rtl/skinny_sbox_feeder_if.sv
// rtl/skinny_sbox_feeder_if.sv - bus between the feeder and the external masked S-box
//
// Purpose : groups the nibble-share, neighbour and randomness lines sent to
//           the S-box and the output shares returned by it.
// Signals : sb_in1..3 (4) nibble shares to the S-box
//           sb_neigh  (8) {in_sh2, in_sh1} nibbles of the next position
//           sb_r      (72) fresh randomness
//           sb_out1..3 (4) S-box output shares
// Modports: master = feeder side, slave = S-box side.
interface skinny_sbox_feeder_if;

   logic [3:0]  sb_in1;
   logic [3:0]  sb_in2;
   logic [3:0]  sb_in3;
   logic [7:0]  sb_neigh;
   logic [71:0] sb_r;
   logic [3:0]  sb_out1;
   logic [3:0]  sb_out2;
   logic [3:0]  sb_out3;

   modport master (
      output sb_in1, sb_in2, sb_in3, sb_neigh, sb_r,
      input  sb_out1, sb_out2, sb_out3
   );

   modport slave (
      input  sb_in1, sb_in2, sb_in3, sb_neigh, sb_r,
      output sb_out1, sb_out2, sb_out3
   );

endinterface

// File: rtl/skinny_sbox_feeder_prng.sv
// rtl/skinny_sbox_feeder_prng.sv - 72-bit LFSR randomness source for the feeder
//
// Purpose : state register plus 72-step advance network. Only present when
//           SKINNY_FEEDER_PRNG_EN is defined; otherwise this file is empty.
// Ports   : clk      clock
//           rst_i    asynchronous active-low reset, state -> SEED_DEFAULT
//           i_load   reseed from i_seed (all-zero seed -> SEED_DEFAULT)
//           i_seed   72-bit seed
//           i_adv    advance the state by 72 LFSR steps
//           o_state  current 72-bit state
`ifdef SKINNY_FEEDER_PRNG_EN
module skinny_prng72
   import skinny_feeder_pkg::*;
#(
   parameter logic [71:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        i_load,
   input  logic [71:0] i_seed,
   input  logic        i_adv,
   output logic [71:0] o_state
);

   logic [71:0] r_state;

   // An all-zero LFSR would lock up, so a zero seed falls back to the default.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= SEED_DEFAULT;
      end else if (i_load) begin
         r_state <= (i_seed == '0) ? SEED_DEFAULT : i_seed;
      end else if (i_adv) begin
         r_state <= lfsr_adv72(r_state);
      end
   end

   assign o_state = r_state;

endmodule
`endif

// File: rtl/skinny_sbox_feeder.sv
// rtl/skinny_sbox_feeder.sv - serialises a three-share 64-bit state through an external masked S-box
//
// Purpose : on start, latches three 64-bit shares, feeds nibbles 0..15 to the
//           S-box one per cycle, collects the S-box output shares SBOX_LAT
//           cycles later and publishes the substituted shares atomically.
// Params  : SBOX_LAT      S-box register stages, legal range 1..4
//           SEED_DEFAULT  PRNG reset state / substitute for a zero seed
// Macro   : SKINNY_FEEDER_PRNG_EN - sb_r from the internal LFSR (skinny_prng72)
//           instead of r_ext.
// Ports   : clk, rst_i (async, active-low)
//           start, in_sh1..3 (64), seed (72), r_ext (72)
//           sbox   S-box bus, master side
//           out_sh1..3 (64), busy, done
module skinny_sbox_feeder
   import skinny_feeder_pkg::*;
#(
   parameter int          SBOX_LAT     = 1,
   parameter logic [71:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
   input  logic                        clk,
   input  logic                        rst_i,
   input  logic                        start,
   input  logic [63:0]                 in_sh1,
   input  logic [63:0]                 in_sh2,
   input  logic [63:0]                 in_sh3,
   input  logic [71:0]                 seed,
   input  logic [71:0]                 r_ext,
   skinny_sbox_feeder_if.master        sbox,
   output logic [63:0]                 out_sh1,
   output logic [63:0]                 out_sh2,
   output logic [63:0]                 out_sh3,
   output logic                        busy,
   output logic                        done
);

   feeder_state_e r_state;
   feeder_state_e w_state_nx;

   logic [3:0]  r_cnt;
   logic [3:0]  r_ccnt;
   logic [63:0] r_sh1, r_sh2, r_sh3;
   logic [63:0] r_acc1, r_acc2, r_acc3;
   logic [63:0] r_out1, r_out2, r_out3;
   logic [SBOX_LAT-1:0] r_vpipe;

   logic        w_accept;
   logic        w_feed;
   logic        w_cap;
   logic        w_last_cap;
   logic [3:0]  w_cnt_nb;
   logic [63:0] w_acc1, w_acc2, w_acc3;
   logic [3:0]  w_sb_in1, w_sb_in2, w_sb_in3;
   logic [7:0]  w_sb_neigh;
   logic [71:0] w_sb_r;
   logic        w_unused;

   // r_vpipe tracks which cycles carried a nibble into the S-box; its last
   // stage marks the cycle in which that nibble's result is on sb_out*.
   assign w_cap      = r_vpipe[SBOX_LAT-1];
   assign w_last_cap = w_cap && (r_ccnt == 4'(NIBBLES-1));
   assign w_cnt_nb   = r_cnt + 4'd1;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_feed     = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_accept   = 1'b1;
               w_state_nx = ST_FEED;
            end
         end
         ST_FEED: begin
            w_feed = 1'b1;
            if (r_cnt == 4'(NIBBLES-1)) begin
               w_state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_last_cap) begin
               w_state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // ---------------- S-box drive ----------------
   // Each share is selected independently; shares of one nibble never meet.
   always_comb begin
      w_sb_in1   = '0;
      w_sb_in2   = '0;
      w_sb_in3   = '0;
      w_sb_neigh = '0;
      if (w_feed) begin
         w_sb_in1   = r_sh1[{r_cnt, 2'b00} +: 4];
         w_sb_in2   = r_sh2[{r_cnt, 2'b00} +: 4];
         w_sb_in3   = r_sh3[{r_cnt, 2'b00} +: 4];
         // w_cnt_nb wraps from 15 to 0, so nibble 15 sees nibble 0 as neighbour.
         w_sb_neigh = {r_sh2[{w_cnt_nb, 2'b00} +: 4], r_sh1[{w_cnt_nb, 2'b00} +: 4]};
      end
   end

`ifdef SKINNY_FEEDER_PRNG_EN
   logic [71:0] w_prng;

   skinny_prng72 #(
      .SEED_DEFAULT (SEED_DEFAULT)
   ) u_prng (
      .clk     (clk),
      .rst_i   (rst_i),
      .i_load  (w_accept),
      .i_seed  (seed),
      .i_adv   (w_feed),
      .o_state (w_prng)
   );

   assign w_sb_r   = w_feed ? w_prng : '0;
   assign w_unused = ^r_ext;
`else
   assign w_sb_r   = w_feed ? r_ext : '0;
   assign w_unused = ^{seed, SEED_DEFAULT};
`endif

   assign sbox.sb_in1   = w_sb_in1;
   assign sbox.sb_in2   = w_sb_in2;
   assign sbox.sb_in3   = w_sb_in3;
   assign sbox.sb_neigh = w_sb_neigh;
   assign sbox.sb_r     = w_sb_r;

   // ---------------- capture ----------------
   always_comb begin
      w_acc1 = r_acc1;
      w_acc2 = r_acc2;
      w_acc3 = r_acc3;
      w_acc1[{r_ccnt, 2'b00} +: 4] = sbox.sb_out1;
      w_acc2[{r_ccnt, 2'b00} +: 4] = sbox.sb_out2;
      w_acc3[{r_ccnt, 2'b00} +: 4] = sbox.sb_out3;
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt   <= '0;
         r_ccnt  <= '0;
         r_vpipe <= '0;
         r_sh1   <= '0;
         r_sh2   <= '0;
         r_sh3   <= '0;
         r_acc1  <= '0;
         r_acc2  <= '0;
         r_acc3  <= '0;
         r_out1  <= '0;
         r_out2  <= '0;
         r_out3  <= '0;
      end else begin
         r_vpipe[0] <= w_feed;
         for (int i = 1; i < SBOX_LAT; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end

         if (w_accept) begin
            r_sh1  <= in_sh1;
            r_sh2  <= in_sh2;
            r_sh3  <= in_sh3;
            r_cnt  <= '0;
            r_ccnt <= '0;
         end else begin
            if (w_feed) begin
               r_cnt <= r_cnt + 4'd1;
            end
            if (w_cap) begin
               r_acc1 <= w_acc1;
               r_acc2 <= w_acc2;
               r_acc3 <= w_acc3;
               r_ccnt <= r_ccnt + 4'd1;
            end
         end

         // Outputs change only as a whole, on the edge that enters DONE,
         // so a half-filled accumulator is never visible.
         if (w_last_cap) begin
            r_out1 <= w_acc1;
            r_out2 <= w_acc2;
            r_out3 <= w_acc3;
         end
      end
   end

   assign out_sh1 = r_out1;
   assign out_sh2 = r_out2;
   assign out_sh3 = r_out3;

endmodule

// File: tb/tb_skinny_sbox_feeder.sv
// tb/tb_skinny_sbox_feeder.sv - self-checking bench for skinny_sbox_feeder
module tb_skinny_sbox_feeder;

   localparam int          LAT      = 1;
   localparam logic [71:0] DEF_SEED = 72'h5AC3E10F96B4D28771;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start;
   logic [63:0] in_sh1, in_sh2, in_sh3;
   logic [71:0] seed;
   logic [71:0] r_ext;
   logic [63:0] out_sh1, out_sh2, out_sh3;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   skinny_sbox_feeder_if sbif();

   skinny_sbox_feeder #(.SBOX_LAT(LAT)) dut (
      .clk     (clk),
      .rst_i   (rst_i),
      .start   (start),
      .in_sh1  (in_sh1),
      .in_sh2  (in_sh2),
      .in_sh3  (in_sh3),
      .seed    (seed),
      .r_ext   (r_ext),
      .sbox    (sbif),
      .out_sh1 (out_sh1),
      .out_sh2 (out_sh2),
      .out_sh3 (out_sh3),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference functions ----------------
   function automatic logic [3:0] sbox4(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
         4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
         4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
         4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
      endcase
   endfunction

   function automatic logic [63:0] ref_sub(input logic [63:0] v);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[4*k +: 4] = sbox4(v[4*k +: 4]);
      return r;
   endfunction

   function automatic logic [3:0] nib(input logic [63:0] v, input int k);
      return v[4*k +: 4];
   endfunction

   function automatic logic [71:0] lfsr72(input logic [71:0] s);
      logic [71:0] v;
      v = s;
      for (int i = 0; i < 72; i++) v = {v[70:0], v[71] ^ v[65] ^ v[24] ^ v[18]};
      return v;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [71:0] rnd72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom() | 32'h1};
      return t[71:0];
   endfunction

   // ---------------- masked S-box model, latency LAT ----------------
   logic [3:0] mask_a, mask_b;
   logic [3:0] m1 [LAT];
   logic [3:0] m2 [LAT];
   logic [3:0] m3 [LAT];

   always @(negedge clk) begin
      mask_a = 4'($urandom());
      mask_b = 4'($urandom());
   end

   always @(posedge clk) begin
      m1[0] <= mask_a;
      m2[0] <= mask_b;
      m3[0] <= sbox4(sbif.sb_in1 ^ sbif.sb_in2 ^ sbif.sb_in3) ^ mask_a ^ mask_b;
      for (int i = 1; i < LAT; i++) begin
         m1[i] <= m1[i-1];
         m2[i] <= m2[i-1];
         m3[i] <= m3[i-1];
      end
   end

   assign sbif.sb_out1 = m1[LAT-1];
   assign sbif.sb_out2 = m2[LAT-1];
   assign sbif.sb_out3 = m3[LAT-1];

   // ---------------- drivers ----------------
   task automatic start_run(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [71:0] s);
      @(negedge clk);
      in_sh1 = a; in_sh2 = b; in_sh3 = c; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // n = cycles from the first FEED cycle (index 0) to the done cycle, -1 on timeout
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 0; i < 100 && n < 0; i++) begin
         if (done === 1'b1) n = i;
         else @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_i = 1'b0; start = 1'b0; r_ext = rnd72(); seed = '0;
      in_sh1 = '0; in_sh2 = '0; in_sh3 = '0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if ({out_sh1, out_sh2, out_sh3} !== '0) begin errors++; $display("FAIL reset_out got %h %h %h exp 0", out_sh1, out_sh2, out_sh3); end
      checks++;
      if ({sbif.sb_in1, sbif.sb_in2, sbif.sb_in3, sbif.sb_neigh, sbif.sb_r} !== '0) begin
         errors++; $display("FAIL reset_sbbus got %h %h %h %h %h exp 0", sbif.sb_in1, sbif.sb_in2, sbif.sb_in3, sbif.sb_neigh, sbif.sb_r);
      end
      @(negedge clk); rst_i = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_unmasked();
      int n;
      logic [63:0] x;
      start_run(64'h0123456789ABCDEF, 64'h0, 64'h0, 72'h0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unmasked_busy got %b exp 1", busy); end
      wait_done(n);
      checks++; if (n !== 16 + LAT) begin errors++; $display("FAIL unmasked_latency got %0d exp %0d", n, 16 + LAT); end
      x = out_sh1 ^ out_sh2 ^ out_sh3;
      checks++; if (x !== 64'hC6901A2B385D4E7F) begin errors++; $display("FAIL unmasked_value got %h exp C6901A2B385D4E7F", x); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b exp 1", busy); end
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy); end
   endtask

   task automatic test_random_split();
      int n;
      logic [63:0] v, s1, s2, x;
      for (int it = 0; it < 4; it++) begin
         v  = (it == 0) ? 64'h0123456789ABCDEF : rnd64();
         s1 = rnd64(); s2 = rnd64();
         start_run(s1, s2, v ^ s1 ^ s2, 72'h0);
         wait_done(n);
         checks++; if (n !== 16 + LAT) begin errors++; $display("FAIL split_latency it=%0d got %0d exp %0d", it, n, 16 + LAT); end
         x = out_sh1 ^ out_sh2 ^ out_sh3;
         checks++; if (x !== ref_sub(v)) begin errors++; $display("FAIL split_value it=%0d got %h exp %h", it, x, ref_sub(v)); end
         repeat (3) @(negedge clk);
         x = out_sh1 ^ out_sh2 ^ out_sh3;
         checks++; if (x !== ref_sub(v)) begin errors++; $display("FAIL split_hold it=%0d got %h exp %h", it, x, ref_sub(v)); end
      end
   endtask

   task automatic test_neigh();
      int n, k1;
      logic [63:0] a, b, c, x;
      a = rnd64(); b = rnd64(); c = rnd64();
      start_run(a, b, c, 72'h0);
      for (int k = 0; k < 16; k++) begin
         // scramble the live inputs: the feeder must use its latched copy
         in_sh1 = rnd64(); in_sh2 = rnd64(); in_sh3 = rnd64();
         r_ext = rnd72();
         #1;
         k1 = (k + 1) % 16;
         checks++;
         if ({sbif.sb_in3, sbif.sb_in2, sbif.sb_in1} !== {nib(c, k), nib(b, k), nib(a, k)}) begin
            errors++; $display("FAIL feed_nibble k=%0d got %h exp %h", k, {sbif.sb_in3, sbif.sb_in2, sbif.sb_in1}, {nib(c, k), nib(b, k), nib(a, k)});
         end
         checks++;
         if (sbif.sb_neigh !== {nib(b, k1), nib(a, k1)}) begin
            errors++; $display("FAIL neigh k=%0d got %h exp %h", k, sbif.sb_neigh, {nib(b, k1), nib(a, k1)});
         end
`ifndef SKINNY_FEEDER_PRNG_EN
         checks++; if (sbif.sb_r !== r_ext) begin errors++; $display("FAIL feed_rext k=%0d got %h exp %h", k, sbif.sb_r, r_ext); end
`endif
         @(negedge clk);
      end
      wait_done(n);
      checks++; if (n !== LAT) begin errors++; $display("FAIL neigh_drain got %0d exp %0d", n, LAT); end
      x = out_sh1 ^ out_sh2 ^ out_sh3;
      checks++; if (x !== ref_sub(a ^ b ^ c)) begin errors++; $display("FAIL neigh_value got %h exp %h", x, ref_sub(a ^ b ^ c)); end
   endtask

   task automatic test_randomness();
      int n;
      @(negedge clk);
      r_ext = rnd72();
      #1;
      checks++;
      if ({sbif.sb_r, sbif.sb_in1, sbif.sb_in2, sbif.sb_in3, sbif.sb_neigh} !== '0) begin
         errors++; $display("FAIL idle_sbbus got r=%h in=%h%h%h nb=%h exp 0", sbif.sb_r, sbif.sb_in1, sbif.sb_in2, sbif.sb_in3, sbif.sb_neigh);
      end
`ifdef SKINNY_FEEDER_PRNG_EN
      for (int s = 0; s < 2; s++) begin
         logic [71:0] sd, exp_r;
         sd    = (s == 0) ? 72'h0 : rnd72();
         exp_r = (sd == 72'h0) ? DEF_SEED : sd;
         start_run(rnd64(), rnd64(), rnd64(), sd);
         for (int k = 0; k < 16; k++) begin
            r_ext = rnd72();
            #1;
            checks++; if (sbif.sb_r !== exp_r) begin errors++; $display("FAIL prng_seq s=%0d k=%0d got %h exp %h", s, k, sbif.sb_r, exp_r); end
            checks++; if (sbif.sb_r === 72'h0) begin errors++; $display("FAIL prng_zero s=%0d k=%0d got 0 exp nonzero", s, k); end
            exp_r = lfsr72(exp_r);
            @(negedge clk);
         end
         wait_done(n);
         checks++; if (n !== LAT) begin errors++; $display("FAIL prng_done got %0d exp %0d", n, LAT); end
      end
`else
      start_run(rnd64(), rnd64(), rnd64(), rnd72());
      for (int k = 0; k < 16; k++) begin
         r_ext = rnd72();
         #1;
         checks++; if (sbif.sb_r !== r_ext) begin errors++; $display("FAIL rext_feed k=%0d got %h exp %h", k, sbif.sb_r, r_ext); end
         @(negedge clk);
      end
      wait_done(n);
      checks++; if (n !== LAT) begin errors++; $display("FAIL rext_done got %0d exp %0d", n, LAT); end
`endif
   endtask

   task automatic test_back_to_back();
      int dn[$];
      int bad_busy;
      int p;
      logic [63:0] a, b, c, x;
      logic exp_busy;
      p = 18 + LAT;
      bad_busy = 0;
      a = rnd64(); b = rnd64(); c = rnd64();
      @(negedge clk);
      in_sh1 = a; in_sh2 = b; in_sh3 = c; start = 1'b1;
      for (int i = 0; i < 4 * p; i++) begin
         @(negedge clk);
         exp_busy = ((i % p) != p - 1);
         if (busy !== exp_busy) bad_busy++;
         if (done === 1'b1) begin
            dn.push_back(i);
            x = out_sh1 ^ out_sh2 ^ out_sh3;
            checks++; if (x !== ref_sub(a ^ b ^ c)) begin errors++; $display("FAIL b2b_value at %0d got %h exp %h", i, x, ref_sub(a ^ b ^ c)); end
         end
      end
      start = 1'b0;
      checks++; if (dn.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", dn.size()); end
      for (int k = 0; k < dn.size() && k < 4; k++) begin
         checks++; if (dn[k] != 16 + LAT + k * p) begin errors++; $display("FAIL b2b_done_at k=%0d got %0d exp %0d", k, dn[k], 16 + LAT + k * p); end
      end
      checks++; if (bad_busy != 0) begin errors++; $display("FAIL b2b_busy got %0d bad cycles exp 0", bad_busy); end
   endtask

   task automatic test_reset_mid();
      int n, seen;
      logic [63:0] v, s1, s2, x;
      start_run(rnd64(), rnd64(), rnd64(), 72'h0);
      repeat (7) @(negedge clk);
      r_ext = rnd72();
      rst_i = 1'b0;
      #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mid_flags got busy=%b done=%b exp 0 0", busy, done); end
      checks++; if ({out_sh1, out_sh2, out_sh3} !== '0) begin errors++; $display("FAIL mid_out got %h %h %h exp 0", out_sh1, out_sh2, out_sh3); end
      checks++;
      if ({sbif.sb_in1, sbif.sb_in2, sbif.sb_in3, sbif.sb_neigh, sbif.sb_r} !== '0) begin
         errors++; $display("FAIL mid_sbbus got %h %h %h %h %h exp 0", sbif.sb_in1, sbif.sb_in2, sbif.sb_in3, sbif.sb_neigh, sbif.sb_r);
      end
      @(negedge clk);
      rst_i = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_done got %0d active cycles exp 0", seen); end
      v = rnd64(); s1 = rnd64(); s2 = rnd64();
      start_run(s1, s2, v ^ s1 ^ s2, 72'h0);
      wait_done(n);
      checks++; if (n !== 16 + LAT) begin errors++; $display("FAIL mid_rerun_latency got %0d exp %0d", n, 16 + LAT); end
      x = out_sh1 ^ out_sh2 ^ out_sh3;
      checks++; if (x !== ref_sub(v)) begin errors++; $display("FAIL mid_rerun_value got %h exp %h", x, ref_sub(v)); end
   endtask

   initial begin
      test_reset();
      test_unmasked();
      test_random_split();
      test_neigh();
      test_randomness();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/skinny_sbox_feeder.md
SKINNY_SBOX_FEEDER -- requirements
Module: skinny_sbox_feeder

Interface
REQ-001 Parameter SBOX_LAT, default 1: register stages in the attached masked S-box; legal range 1..4.
REQ-002 Parameter SEED_DEFAULT, default 72'h5A_C3E1_0F96_B4D2_8771: PRNG state after reset, and the substitute for an all-zero seed.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request to process one 64-bit, three-share state.
REQ-006 in_sh1, in_sh2, in_sh3  in  64 each  input state shares; nibble k = bits [4k+3:4k].
REQ-007 seed  in  72  PRNG seed, sampled with start.
REQ-008 r_ext  in  72  external fresh randomness.
REQ-009 sb_in1, sb_in2, sb_in3  out  4 each  current nibble shares to the S-box.
REQ-010 sb_neigh  out  8  neighbouring-share bus to the S-box.
REQ-011 sb_r  out  72  fresh randomness to the S-box.
REQ-012 sb_out1, sb_out2, sb_out3  in  4 each  S-box output shares.
REQ-013 out_sh1, out_sh2, out_sh3  out  64 each  substituted state shares.
REQ-014 busy  out  1  high from the accepted start until done, inclusive.
REQ-015 done  out  1  single-cycle pulse; the out_sh* registers are complete.

Function
REQ-016 FSM states: IDLE, FEED, DRAIN, DONE.
REQ-017 IDLE -> FEED on start=1:
- latch in_sh1..3 into internal registers;
- clear the nibble counter cnt (4 bit).
REQ-018 FEED: drive nibble cnt on sb_in1..3; sb_neigh = {in_sh2 nibble (cnt+1) mod 16, in_sh1 nibble (cnt+1) mod 16}; cnt increments each cycle; cnt=15 -> DRAIN.
REQ-019 Outside FEED: sb_in*, sb_neigh and sb_r are driven all-zero.
REQ-020 Capture: sb_out* sampled SBOX_LAT cycles after its nibble was driven is written to nibble (cnt - SBOX_LAT) of out_sh1..3; a capture counter tracks this.
REQ-021 DRAIN lasts SBOX_LAT cycles to finish the remaining captures, then -> DONE.
REQ-022 DONE lasts one cycle with done=1, then -> IDLE; with SBOX_LAT=1, done is high in the cycle that starts 17 edges after the start-sampling edge.
REQ-023 out_sh* hold their value from DONE until the next accepted start, and are never partially visible while done=0.
REQ-024 start is ignored while busy=1; no queuing.
REQ-025 start asserted in the DONE cycle is ignored; start asserted in the following IDLE cycle is accepted.
REQ-026 Input shares are never recombined: no logic combines shares of the same nibble.

Reset
REQ-027 rst_i=0 forces, asynchronously:
- FSM to IDLE, cnt=0, capture counter=0;
- busy=0, done=0;
- out_sh*, sb_in*, sb_neigh, sb_r and latched shares all zero;
- PRNG state to SEED_DEFAULT.
REQ-028 Reset mid-operation discards the run; no done pulse follows.

Configuration
REQ-029 Macro SKINNY_FEEDER_PRNG_EN defined: sb_r comes from the internal 72-bit Fibonacci LFSR (taps 72,66,25,19), advanced 72 steps per FEED cycle; reseeded from seed on an accepted start (zero seed -> SEED_DEFAULT); r_ext ignored.
REQ-030 Macro undefined: no LFSR is instantiated; sb_r = r_ext during FEED, zero otherwise; seed ignored.

Structure
REQ-031 Package skinny_feeder_pkg holds:
- the FSM state enum;
- NIBBLES=16;
- the LFSR tap constants;
- the SEED_DEFAULT value.
REQ-032 The sub-module skinny_prng72 (LFSR step network plus state register) is instantiated only under SKINNY_FEEDER_PRNG_EN.
REQ-033 The S-box is external; this block contains no S-box logic.

Verification
REQ-034 The bench covers these directed scenarios, each paired with a behavioural masked S-box model of latency SBOX_LAT:
- Unmasked input: in_sh1=64'h0123456789ABCDEF, in_sh2=in_sh3=0 -> out_sh1^out_sh2^out_sh3 = 64'hC6901A2B385D4E7F; done after 17 cycles.
- Random three-way split of the same value -> same XOR result.
- Per-cycle check: sb_neigh equals the in_sh2/in_sh1 nibbles (cnt+1) mod 16, including the wrap at cnt=15 to nibble 0.
- start held high continuously -> runs back-to-back, each run starting two cycles after the previous done pulse; no start accepted while busy.
- rst_i pulsed low at FEED cnt=7 -> all outputs zero immediately, no done pulse; a subsequent start completes normally.
- With SKINNY_FEEDER_PRNG_EN: seed=0 -> LFSR sequence identical to SEED_DEFAULT reseed; sb_r is never all-zero during FEED.
- Without SKINNY_FEEDER_PRNG_EN: sb_r equals r_ext during FEED and is zero in IDLE.
